// File: rtl/npc_axi_pkg.sv
// Shared AXI4-lite constants and fetch FSM encoding for the NPC instruction fetch path.
package npc_axi_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_AR   = 2'd1;
  localparam fetch_state_t ST_R    = 2'd2;
  localparam fetch_state_t ST_HOLD = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Instruction access, secure, unprivileged.
  localparam logic [2:0] ARPROT_INSTR = 3'b100;

  // A 64-bit beat carries two instructions; PC bit 2 picks which one.
  function automatic logic [31:0] pick_lane(input logic [63:0] beat, input logic upper);
    return upper ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/ifu_axi_lite_fetch.sv
// AXI4-lite read master for the IFU: one AR/R transaction per fetch request.
// Optional macro ACCESS_FAULT_EN adds fetch_fault for error responses and misaligned PCs.
module ifu_axi_lite_fetch
  import npc_axi_pkg::*;
#(
  parameter int         ADDR_W     = 64,
  parameter int         DATA_W     = 64,
  parameter logic [2:0] ARPROT_VAL = ARPROT_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_instr_start,
  input  logic [ADDR_W-1:0] PC_addr,
  output logic              read_instr_finish,
  output logic [31:0]       INSTR_READ,
`ifdef ACCESS_FAULT_EN
  output logic              fetch_fault,
`endif
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [2:0]        arprot,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  fetch_state_t state;
  logic         lane;
  logic         misaligned;
  logic         unused_bits;

  assign arprot      = ARPROT_VAL;
  assign unused_bits = ^{rresp, PC_addr[1:0]};

`ifdef ACCESS_FAULT_EN
  assign misaligned = |PC_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // HOLD absorbs a start that stays high, so each assertion yields exactly one fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      arvalid           <= 1'b0;
      rready            <= 1'b0;
      read_instr_finish <= 1'b0;
      INSTR_READ        <= '0;
      araddr            <= '0;
      lane              <= 1'b0;
    end else begin
      read_instr_finish <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read_instr_start) begin
            if (misaligned) begin
              INSTR_READ        <= '0;
              read_instr_finish <= 1'b1;
              state             <= ST_HOLD;
            end else begin
              araddr  <= {PC_addr[ADDR_W-1:3], 3'b000};
              lane    <= PC_addr[2];
              arvalid <= 1'b1;
              state   <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid && rready) begin
            INSTR_READ        <= pick_lane(rdata[63:0], lane);
            read_instr_finish <= 1'b1;
            rready            <= 1'b0;
            state             <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!read_instr_start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACCESS_FAULT_EN
  // Fault flag rides alongside the finish pulse and holds until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_fault <= 1'b0;
    end else if (state == ST_IDLE && read_instr_start) begin
      fetch_fault <= misaligned;
    end else if (state == ST_R && rvalid && rready) begin
      fetch_fault <= (rresp != RESP_OKAY);
    end
  end
`endif

endmodule

// File: tb/tb_ifu_axi_lite_fetch.sv
// Directed bench for ifu_axi_lite_fetch with a delay-programmable AXI4-lite slave model.
// Fault-path scenarios are compiled in when ACCESS_FAULT_EN is defined.
module tb_ifu_axi_lite_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_instr_start;
  logic [63:0] PC_addr;
  logic        read_instr_finish;
  logic [31:0] INSTR_READ;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arprot;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
`ifdef ACCESS_FAULT_EN
  logic        fetch_fault;
`endif

  int total = 0;
  int bad   = 0;

  int         ar_delay  = 0;
  int         r_delay   = 0;
  bit         rand_mode = 1'b0;
  logic [1:0] resp_cfg  = 2'b00;

  logic        was_rst      = 1'b1;
  logic        ar_fire      = 1'b0;
  logic        r_fire       = 1'b0;
  logic [63:0] ar_fire_addr = '0;
  logic [63:0] last_ar_addr = '0;
  logic [63:0] r_addr       = '0;
  bit          r_pending    = 1'b0;
  int          ar_cnt       = 0;
  int          r_cnt        = 0;
  int          cur_ar       = 0;
  int          cur_r        = 0;
  int          ar_hs_total  = 0;

  logic        prev_arvalid = 1'b0;
  logic        prev_rready  = 1'b0;
  logic [63:0] prev_araddr  = '0;
  int          arvalid_cycles = 0;
  int          rready_cycles  = 0;

  always #5 clk = ~clk;

  ifu_axi_lite_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .read_instr_start  (read_instr_start),
    .PC_addr           (PC_addr),
    .read_instr_finish (read_instr_finish),
    .INSTR_READ        (INSTR_READ),
`ifdef ACCESS_FAULT_EN
    .fetch_fault       (fetch_fault),
`endif
    .araddr            (araddr),
    .arvalid           (arvalid),
    .arready           (arready),
    .arprot            (arprot),
    .rdata             (rdata),
    .rresp             (rresp),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  // Memory contents: two fixed words for the directed cases, a hash elsewhere.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0010_0093_0000_0013;
    if (a == 64'h8000_0008) return 64'hCAFE_F00D_1234_5678;
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  always @(posedge clk) begin
    was_rst      <= rst;
    ar_fire      <= arvalid && arready && !rst;
    ar_fire_addr <= araddr;
    r_fire       <= rvalid && rready && !rst;
  end

  // Slave: arready after cur_ar waiting cycles, rvalid after cur_r cycles past the AR handshake.
  always @(negedge clk) begin
    if (was_rst) begin
      arready   = 1'b0;
      rvalid    = 1'b0;
      r_pending = 1'b0;
      ar_cnt    = 0;
      r_cnt     = 0;
    end else begin
      if (ar_fire) begin
        ar_hs_total++;
        last_ar_addr = ar_fire_addr;
        r_addr       = ar_fire_addr;
        r_pending    = 1'b1;
        r_cnt        = 0;
        cur_r        = rand_mode ? int'($urandom_range(0, 4)) : r_delay;
      end
      if (r_fire) begin
        rvalid    = 1'b0;
        r_pending = 1'b0;
      end
      if (arvalid) begin
        if (ar_cnt == 0) cur_ar = rand_mode ? int'($urandom_range(0, 4)) : ar_delay;
        arready = (ar_cnt >= cur_ar);
        ar_cnt++;
      end else begin
        arready = 1'b0;
        ar_cnt  = 0;
      end
      if (r_pending && !rvalid) begin
        if (r_cnt >= cur_r) begin
          rvalid = 1'b1;
          rdata  = mem_word(r_addr);
          rresp  = resp_cfg;
        end else begin
          r_cnt++;
        end
      end
    end
  end

  // AXI stability: valid/ready never withdrawn before handshake, address steady, channels exclusive.
  always @(negedge clk) begin
    if (!was_rst) begin
      if (prev_arvalid && !ar_fire) begin
        total++;
        if (arvalid !== 1'b1 || araddr !== prev_araddr) begin
          bad++;
          $display("[TB] FAIL ar_stable: arvalid=%b araddr=%h required arvalid=1 araddr=%h",
                   arvalid, araddr, prev_araddr);
        end
      end
      if (prev_rready && !r_fire) begin
        total++;
        if (rready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL r_stable: rready=%b required 1", rready);
        end
      end
      if (arvalid || rready) begin
        total++;
        if (arvalid && rready) begin
          bad++;
          $display("[TB] FAIL ar_r_exclusive: arvalid=%b rready=%b required not both", arvalid, rready);
        end
      end
    end
    if (arvalid) arvalid_cycles++;
    if (rready)  rready_cycles++;
    prev_arvalid = arvalid;
    prev_rready  = rready;
    prev_araddr  = araddr;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_fetch(input logic [63:0] pc, input int budget, output int lat);
    @(negedge clk);
    read_instr_start = 1'b1;
    PC_addr          = pc;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (read_instr_finish) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic end_fetch;
    @(negedge clk);
    read_instr_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (arvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_arvalid: got %b want 0", arvalid); end
    total++; if (rready !== 1'b0) begin bad++; $display("[TB] FAIL rst_rready: got %b want 0", rready); end
    total++; if (read_instr_finish !== 1'b0) begin bad++; $display("[TB] FAIL rst_finish: got %b want 0", read_instr_finish); end
    total++; if (INSTR_READ !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr: got %h want 0", INSTR_READ); end
    total++; if (araddr !== 64'h0) begin bad++; $display("[TB] FAIL rst_araddr: got %h want 0", araddr); end
    total++; if (arprot !== 3'b100) begin bad++; $display("[TB] FAIL arprot: got %b want 100", arprot); end
`ifdef ACCESS_FAULT_EN
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("[TB] FAIL rst_fault: got %b want 0", fetch_fault); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_min_latency;
    int lat;
    ar_delay = 0; r_delay = 0;
    do_fetch(64'h8000_0004, 20, lat);
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL min_latency: got %0d want 3", lat); end
    total++; if (INSTR_READ !== 32'h0010_0093) begin bad++; $display("[TB] FAIL min_data: got %h want 00100093", INSTR_READ); end
    total++; if (last_ar_addr !== 64'h8000_0000) begin bad++; $display("[TB] FAIL min_araddr: got %h want 80000000", last_ar_addr); end
    @(negedge clk);
    total++; if (read_instr_finish !== 1'b0) begin bad++; $display("[TB] FAIL finish_pulse: got %b want 0", read_instr_finish); end
    end_fetch;
  endtask

  task automatic test_stalls;
    int lat, a0, r0;
    a0 = arvalid_cycles; r0 = rready_cycles;
    ar_delay = 5; r_delay = 2;
    do_fetch(64'h8000_0014, 40, lat);
    total++; if (lat != 10) begin bad++; $display("[TB] FAIL stall_latency: got %0d want 10", lat); end
    total++; if (INSTR_READ !== 32'h25A5_5A4A) begin bad++; $display("[TB] FAIL stall_data: got %h want 25a55a4a", INSTR_READ); end
    end_fetch;
    total++; if (arvalid_cycles - a0 != 6) begin bad++; $display("[TB] FAIL stall_arvalid_cycles: got %0d want 6", arvalid_cycles - a0); end
    total++; if (rready_cycles - r0 != 3) begin bad++; $display("[TB] FAIL stall_rready_cycles: got %0d want 3", rready_cycles - r0); end
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_back_to_back;
    int lat, hs0;
    hs0 = ar_hs_total;
    do_fetch(64'h8000_0004, 20, lat);
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL held_latency: got %0d want 3", lat); end
    repeat (20) @(negedge clk);
    total++; if (ar_hs_total - hs0 != 1) begin bad++; $display("[TB] FAIL held_one_ar: got %0d want 1", ar_hs_total - hs0); end
    end_fetch;
    do_fetch(64'h8000_0008, 20, lat);
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL second_latency: got %0d want 3", lat); end
    total++; if (INSTR_READ !== 32'h1234_5678) begin bad++; $display("[TB] FAIL second_data: got %h want 12345678", INSTR_READ); end
    end_fetch;
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    r_delay = 100;
    @(negedge clk);
    read_instr_start = 1'b1;
    PC_addr          = 64'h8000_0010;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rready) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL reach_r: rready got 0 want 1"); end
    rst = 1'b1;
    read_instr_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total++; if (arvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_arvalid: got %b want 0", arvalid); end
    total++; if (rready !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_rready: got %b want 0", rready); end
    total++; if (read_instr_finish !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_finish: got %b want 0", read_instr_finish); end
    total++; if (INSTR_READ !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_instr: got %h want 0", INSTR_READ); end
    r_delay = 0;
    do_fetch(64'h8000_0008, 20, lat);
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL post_rst_latency: got %0d want 3", lat); end
    total++; if (INSTR_READ !== 32'h1234_5678) begin bad++; $display("[TB] FAIL post_rst_data: got %h want 12345678", INSTR_READ); end
    end_fetch;
  endtask

  task automatic test_resp_and_align;
    int lat, hs0, a0;
    resp_cfg = 2'b10;
    do_fetch(64'h8000_0000, 20, lat);
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL slverr_latency: got %0d want 3", lat); end
    total++; if (INSTR_READ !== 32'h0000_0013) begin bad++; $display("[TB] FAIL slverr_data: got %h want 00000013", INSTR_READ); end
`ifdef ACCESS_FAULT_EN
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("[TB] FAIL slverr_fault: got %b want 1", fetch_fault); end
`endif
    end_fetch;
    resp_cfg = 2'b00;
`ifdef ACCESS_FAULT_EN
    do_fetch(64'h8000_0004, 20, lat);
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("[TB] FAIL okay_fault: got %b want 0", fetch_fault); end
    end_fetch;
    hs0 = ar_hs_total; a0 = arvalid_cycles;
    do_fetch(64'h8000_0002, 20, lat);
    total++; if (lat != 1) begin bad++; $display("[TB] FAIL misalign_latency: got %0d want 1", lat); end
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("[TB] FAIL misalign_fault: got %b want 1", fetch_fault); end
    total++; if (INSTR_READ !== 32'h0) begin bad++; $display("[TB] FAIL misalign_data: got %h want 0", INSTR_READ); end
    end_fetch;
    total++; if (ar_hs_total != hs0 || arvalid_cycles != a0) begin
      bad++; $display("[TB] FAIL misalign_no_ar: handshakes=%0d arvalid_cycles=%0d want 0 0",
                      ar_hs_total - hs0, arvalid_cycles - a0);
    end
`else
    do_fetch(64'h8000_0006, 20, lat);
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL trunc_latency: got %0d want 3", lat); end
    total++; if (INSTR_READ !== 32'h0010_0093) begin bad++; $display("[TB] FAIL trunc_data: got %h want 00100093", INSTR_READ); end
    total++; if (last_ar_addr !== 64'h8000_0000) begin bad++; $display("[TB] FAIL trunc_araddr: got %h want 80000000", last_ar_addr); end
    end_fetch;
`endif
  endtask

  task automatic test_random;
    int lat;
    int unsigned w;
    logic [63:0] pc, beat;
    logic [31:0] exp;
    rand_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      w    = $urandom_range(0, 16383);
      pc   = 64'h8000_0000 + 64'(w) * 64'd4;
      beat = mem_word({pc[63:3], 3'b000});
      exp  = pc[2] ? beat[63:32] : beat[31:0];
      do_fetch(pc, 40, lat);
      total++;
      if (lat < 0 || INSTR_READ !== exp) begin
        bad++;
        $display("[TB] FAIL random_fetch pc=%h: latency=%0d data=%h want data=%h", pc, lat, INSTR_READ, exp);
      end
      end_fetch;
    end
    rand_mode = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    read_instr_start = 1'b0;
    PC_addr = '0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    test_reset;
    test_min_latency;
    test_stalls;
    test_back_to_back;
    test_reset_mid;
    test_resp_and_align;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
